// File: rtl/multdiv_issue_scheduler.sv
// Arbitrates the shared multicycle mult/div unit between the two DX issue slots.
// Slot A (older) runs first, slot B second, and both results retire in one write-back cycle.
module multdiv_issue_scheduler #(
  parameter int WIDTH   = 32,
  parameter int REGW    = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             isdiv_a,
  input  logic             isdiv_b,
  input  logic [WIDTH-1:0] opA_a,
  input  logic [WIDTH-1:0] opB_a,
  input  logic [WIDTH-1:0] opA_b,
  input  logic [WIDTH-1:0] opB_b,
  input  logic [REGW-1:0]  rd_a,
  input  logic [REGW-1:0]  rd_b,
  input  logic             flush,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_operandA,
  output logic [WIDTH-1:0] data_operandB,
  input  logic [WIDTH-1:0] data_result,
  input  logic             data_exception,
  input  logic             data_resultRDY,
  output logic             stall,
  output logic             wb_valid_a,
  output logic             wb_valid_b,
  output logic [REGW-1:0]  wb_rd_a,
  output logic [REGW-1:0]  wb_rd_b,
  output logic [WIDTH-1:0] wb_data_a,
  output logic [WIDTH-1:0] wb_data_b,
  output logic             wb_exc_a,
  output logic             wb_exc_b
);

  localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN_A = 3'd1;
  localparam logic [2:0] S_RUN_B = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]       state_reg,      state_next;
  logic             pend_a_reg,     pend_a_next;
  logic             pend_b_reg,     pend_b_next;
  logic             isdiv_b_reg,    isdiv_b_next;
  logic [WIDTH-1:0] opa_b_reg,      opa_b_next;
  logic [WIDTH-1:0] opb_b_reg,      opb_b_next;
  logic [REGW-1:0]  rd_a_reg,       rd_a_next;
  logic [REGW-1:0]  rd_b_reg,       rd_b_next;
  logic [WIDTH-1:0] res_a_reg,      res_a_next;
  logic [WIDTH-1:0] res_b_reg,      res_b_next;
  logic             exc_a_reg,      exc_a_next;
  logic             exc_b_reg,      exc_b_next;
  logic [CNTW-1:0]  cnt_reg,        cnt_next;
  logic             mult_reg,       mult_next;
  logic             div_reg,        div_next;
  logic [WIDTH-1:0] opnd_a_reg,     opnd_a_next;
  logic [WIDTH-1:0] opnd_b_reg,     opnd_b_next;
  logic             wb_valid_a_reg, wb_valid_a_next;
  logic             wb_valid_b_reg, wb_valid_b_next;

  logic             any_req;
  logic             pulse_cycle;
  logic             rdy_seen;
  logic             timed_out;
  logic             op_done;
  logic [WIDTH-1:0] done_data;
  logic             done_exc;

  assign any_req     = req_a | req_b;
  // The start-pulse cycle is the only one where a RDY cannot belong to our op.
  assign pulse_cycle = mult_reg | div_reg;
  assign rdy_seen    = data_resultRDY & ~pulse_cycle;
  assign timed_out   = (cnt_reg == CNT_LAST);
  assign op_done     = rdy_seen | timed_out;
  assign done_data   = rdy_seen ? data_result : '0;
  assign done_exc    = rdy_seen ? data_exception : 1'b1;

  always_comb begin
    state_next      = state_reg;
    pend_a_next     = pend_a_reg;
    pend_b_next     = pend_b_reg;
    isdiv_b_next    = isdiv_b_reg;
    opa_b_next      = opa_b_reg;
    opb_b_next      = opb_b_reg;
    rd_a_next       = rd_a_reg;
    rd_b_next       = rd_b_reg;
    res_a_next      = res_a_reg;
    res_b_next      = res_b_reg;
    exc_a_next      = exc_a_reg;
    exc_b_next      = exc_b_reg;
    cnt_next        = timed_out ? cnt_reg : cnt_reg + 1'b1;
    mult_next       = 1'b0;
    div_next        = 1'b0;
    opnd_a_next     = opnd_a_reg;
    opnd_b_next     = opnd_b_reg;
    wb_valid_a_next = 1'b0;
    wb_valid_b_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (any_req && !flush) begin
          pend_a_next  = req_a;
          pend_b_next  = req_b;
          isdiv_b_next = isdiv_b;
          opa_b_next   = opA_b;
          opb_b_next   = opB_b;
          rd_a_next    = rd_a;
          rd_b_next    = rd_b;
          cnt_next     = '0;
          if (req_a) begin
            state_next  = S_RUN_A;
            mult_next   = ~isdiv_a;
            div_next    = isdiv_a;
            opnd_a_next = opA_a;
            opnd_b_next = opB_a;
          end else begin
            state_next  = S_RUN_B;
            mult_next   = ~isdiv_b;
            div_next    = isdiv_b;
            opnd_a_next = opA_b;
            opnd_b_next = opB_b;
          end
        end
      end

      S_RUN_A: begin
        if (flush) begin
          pend_a_next = 1'b0;
          pend_b_next = 1'b0;
          // A result arriving with the flush leaves the unit empty: no drain needed.
          state_next  = op_done ? S_IDLE : S_DRAIN;
        end else if (op_done) begin
          res_a_next = done_data;
          exc_a_next = done_exc;
          if (pend_b_reg) begin
            state_next  = S_RUN_B;
            mult_next   = ~isdiv_b_reg;
            div_next    = isdiv_b_reg;
            opnd_a_next = opa_b_reg;
            opnd_b_next = opb_b_reg;
            cnt_next    = '0;
          end else begin
            state_next      = S_WB;
            wb_valid_a_next = pend_a_reg;
            wb_valid_b_next = 1'b0;
          end
        end
      end

      S_RUN_B: begin
        if (flush) begin
          pend_a_next = 1'b0;
          pend_b_next = 1'b0;
          state_next  = op_done ? S_IDLE : S_DRAIN;
        end else if (op_done) begin
          res_b_next      = done_data;
          exc_b_next      = done_exc;
          state_next      = S_WB;
          wb_valid_a_next = pend_a_reg;
          wb_valid_b_next = pend_b_reg;
        end
      end

      S_WB: begin
        // req_* still show the retiring instructions here, so they are not re-accepted.
        state_next  = S_IDLE;
        pend_a_next = 1'b0;
        pend_b_next = 1'b0;
      end

      S_DRAIN: begin
        if (op_done) state_next = S_IDLE;
      end

      default: begin
        state_next  = S_IDLE;
        pend_a_next = 1'b0;
        pend_b_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      pend_a_reg     <= 1'b0;
      pend_b_reg     <= 1'b0;
      isdiv_b_reg    <= 1'b0;
      opa_b_reg      <= '0;
      opb_b_reg      <= '0;
      rd_a_reg       <= '0;
      rd_b_reg       <= '0;
      res_a_reg      <= '0;
      res_b_reg      <= '0;
      exc_a_reg      <= 1'b0;
      exc_b_reg      <= 1'b0;
      cnt_reg        <= '0;
      mult_reg       <= 1'b0;
      div_reg        <= 1'b0;
      opnd_a_reg     <= '0;
      opnd_b_reg     <= '0;
      wb_valid_a_reg <= 1'b0;
      wb_valid_b_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_a_reg     <= pend_a_next;
      pend_b_reg     <= pend_b_next;
      isdiv_b_reg    <= isdiv_b_next;
      opa_b_reg      <= opa_b_next;
      opb_b_reg      <= opb_b_next;
      rd_a_reg       <= rd_a_next;
      rd_b_reg       <= rd_b_next;
      res_a_reg      <= res_a_next;
      res_b_reg      <= res_b_next;
      exc_a_reg      <= exc_a_next;
      exc_b_reg      <= exc_b_next;
      cnt_reg        <= cnt_next;
      mult_reg       <= mult_next;
      div_reg        <= div_next;
      opnd_a_reg     <= opnd_a_next;
      opnd_b_reg     <= opnd_b_next;
      wb_valid_a_reg <= wb_valid_a_next;
      wb_valid_b_reg <= wb_valid_b_next;
    end
  end

  assign stall = (state_reg == S_RUN_A) || (state_reg == S_RUN_B) ||
                 ((state_reg == S_IDLE) && any_req && !flush) ||
                 ((state_reg == S_DRAIN) && any_req);

  assign ctrl_MULT     = mult_reg;
  assign ctrl_DIV      = div_reg;
  assign data_operandA = opnd_a_reg;
  assign data_operandB = opnd_b_reg;
  assign wb_valid_a    = wb_valid_a_reg;
  assign wb_valid_b    = wb_valid_b_reg;
  assign wb_rd_a       = rd_a_reg;
  assign wb_rd_b       = rd_b_reg;
  assign wb_data_a     = res_a_reg;
  assign wb_data_b     = res_b_reg;
  assign wb_exc_a      = exc_a_reg;
  assign wb_exc_b      = exc_b_reg;

endmodule

// File: tb/tb_multdiv_issue_scheduler.sv
// Bench for multdiv_issue_scheduler: a latency-programmable mult/div unit model,
// a directed vector table, randomized transactions against a transaction-level model, and flush/reset sequences.
module tb_multdiv_issue_scheduler;
  localparam int W  = 32;
  localparam int RW = 5;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_a = 0, req_b = 0, isdiv_a = 0, isdiv_b = 0, flush = 0;
  logic [W-1:0]  opA_a = 0, opB_a = 0, opA_b = 0, opB_b = 0;
  logic [RW-1:0] rd_a = 0, rd_b = 0;
  logic          ctrl_MULT, ctrl_DIV, stall;
  logic [W-1:0]  data_operandA, data_operandB;
  logic [W-1:0]  data_result = 0;
  logic          data_exception = 0, data_resultRDY = 0;
  logic          wb_valid_a, wb_valid_b, wb_exc_a, wb_exc_b;
  logic [RW-1:0] wb_rd_a, wb_rd_b;
  logic [W-1:0]  wb_data_a, wb_data_b;

  multdiv_issue_scheduler #(.WIDTH(W), .REGW(RW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .req_b(req_b), .isdiv_a(isdiv_a), .isdiv_b(isdiv_b),
    .opA_a(opA_a), .opB_a(opB_a), .opA_b(opA_b), .opB_b(opB_b),
    .rd_a(rd_a), .rd_b(rd_b), .flush(flush),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .stall(stall),
    .wb_valid_a(wb_valid_a), .wb_valid_b(wb_valid_b),
    .wb_rd_a(wb_rd_a), .wb_rd_b(wb_rd_b),
    .wb_data_a(wb_data_a), .wb_data_b(wb_data_b),
    .wb_exc_a(wb_exc_a), .wb_exc_b(wb_exc_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit ra, rb, da, db;
    logic [W-1:0] a0, b0, a1, b1;
    logic [RW-1:0] rda, rdb;
    int la, lb;          // RDY latency after the start pulse; 0 = unit never answers
    int exp_stall;
    bit exp_va, exp_vb;
    logic [W-1:0] exp_da, exp_db;
    bit exp_ea, exp_eb;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // unit model state
  int           lat_q[$];
  int           ucnt = 0;
  logic [W-1:0] u_a = 0, u_b = 0;
  bit           u_div = 0;
  bit           pulse_div_q[$];
  logic [W-1:0] pulse_opa_q[$];
  logic [W-1:0] pulse_opb_q[$];
  bit           both_high = 0;

  // per-cycle snapshot
  bit s_stall, s_wva, s_wvb, s_ea, s_eb, s_mul, s_div;
  logic [W-1:0] s_da, s_db;
  logic [RW-1:0] s_rda, s_rdb;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] unit_calc(bit d, logic [W-1:0] a, logic [W-1:0] b);
    if (d) return (b == 0) ? {W{1'b1}} : a / b;
    return a * b;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    int l;
    data_resultRDY = 0;
    data_result    = 0;
    data_exception = 0;
    if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) begin
        data_resultRDY = 1;
        data_result    = unit_calc(u_div, u_a, u_b);
        data_exception = u_div && (u_b == 0);
      end
    end
    #1;
    s_stall = stall; s_wva = wb_valid_a; s_wvb = wb_valid_b;
    s_da = wb_data_a; s_db = wb_data_b; s_ea = wb_exc_a; s_eb = wb_exc_b;
    s_rda = wb_rd_a; s_rdb = wb_rd_b; s_mul = ctrl_MULT; s_div = ctrl_DIV;
    if (ctrl_MULT && ctrl_DIV) both_high = 1;
    if (ctrl_MULT || ctrl_DIV) begin
      pulse_div_q.push_back(ctrl_DIV);
      pulse_opa_q.push_back(data_operandA);
      pulse_opb_q.push_back(data_operandB);
      u_a = data_operandA; u_b = data_operandB; u_div = ctrl_DIV;
      l = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      ucnt = l;
    end
    @(negedge clock);
  endtask

  function automatic int run_len(int l);
    return (l == 0) ? TO : l + 1;
  endfunction

  // Transaction-level expectation: stall covers acceptance plus every op's run.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    r.exp_stall = 1 + (v.ra ? run_len(v.la) : 0) + (v.rb ? run_len(v.lb) : 0);
    r.exp_va = v.ra;
    r.exp_vb = v.rb;
    r.exp_da = (v.la == 0) ? '0 : unit_calc(v.da, v.a0, v.b0);
    r.exp_ea = (v.la == 0) ? 1'b1 : (v.da && v.b0 == 0);
    r.exp_db = (v.lb == 0) ? '0 : unit_calc(v.db, v.a1, v.b1);
    r.exp_eb = (v.lb == 0) ? 1'b1 : (v.db && v.b1 == 0);
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int  nst = 0;
    bit  seen = 0;
    bit  fd;
    logic [W-1:0] fa, fb;
    pulse_div_q = {}; pulse_opa_q = {}; pulse_opb_q = {}; lat_q = {}; both_high = 0;
    if (v.ra) lat_q.push_back(v.la);
    if (v.rb) lat_q.push_back(v.lb);
    req_a = v.ra; req_b = v.rb; isdiv_a = v.da; isdiv_b = v.db;
    opA_a = v.a0; opB_a = v.b0; opA_b = v.a1; opB_b = v.b1; rd_a = v.rda; rd_b = v.rdb;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (s_wva || s_wvb) seen = 1;
      else if (s_stall) nst++;
    end
    req_a = 0; req_b = 0;
    chk({tag, " wb_seen"}, W'(seen), W'(1));
    chk({tag, " stall_cycles"}, W'(nst), W'(v.exp_stall));
    chk({tag, " stall_in_wb"}, W'(s_stall), W'(0));
    chk({tag, " wb_valid_a"}, W'(s_wva), W'(v.exp_va));
    chk({tag, " wb_valid_b"}, W'(s_wvb), W'(v.exp_vb));
    if (v.ra) begin
      chk({tag, " wb_data_a"}, s_da, v.exp_da);
      chk({tag, " wb_exc_a"}, W'(s_ea), W'(v.exp_ea));
      chk({tag, " wb_rd_a"}, W'(s_rda), W'(v.rda));
    end
    if (v.rb) begin
      chk({tag, " wb_data_b"}, s_db, v.exp_db);
      chk({tag, " wb_exc_b"}, W'(s_eb), W'(v.exp_eb));
      chk({tag, " wb_rd_b"}, W'(s_rdb), W'(v.rdb));
    end
    chk({tag, " pulse_count"}, W'(pulse_div_q.size()), W'(int'(v.ra) + int'(v.rb)));
    chk({tag, " mult_div_exclusive"}, W'(both_high), W'(0));
    if (pulse_div_q.size() > 0) begin
      fd = v.ra ? v.da : v.db;
      fa = v.ra ? v.a0 : v.a1;
      fb = v.ra ? v.b0 : v.b1;
      chk({tag, " pulse0_isdiv"}, W'(pulse_div_q[0]), W'(fd));
      chk({tag, " pulse0_opA"}, pulse_opa_q[0], fa);
      chk({tag, " pulse0_opB"}, pulse_opb_q[0], fb);
    end
    if (pulse_div_q.size() > 1 && v.ra && v.rb) begin
      chk({tag, " pulse1_isdiv"}, W'(pulse_div_q[1]), W'(v.db));
      chk({tag, " pulse1_opA"}, pulse_opa_q[1], v.a1);
    end
    $display("txn %s: ra=%0d rb=%0d stall=%0d wb_a=%0d/%0h/%0d wb_b=%0d/%0h/%0d",
             tag, v.ra, v.rb, nst, s_wva, s_da, s_ea, s_wvb, s_db, s_eb);
  endtask

  vec_t tbl[5];
  vec_t rv;
  int   bad_cyc;

  initial begin
    // directed table: {ra,rb,da,db, a0,b0,a1,b1, rda,rdb, la,lb, stall, va,vb, da,db, ea,eb}
    tbl[0] = '{1,0,0,0, 7,6,0,0,       3,0, 3,0, 5,  1,0, 42,0,           0,0};
    tbl[1] = '{1,1,0,1, 5,5,100,7,     1,2, 2,4, 9,  1,1, 25,14,          0,0};
    tbl[2] = '{0,1,0,1, 0,0,9,0,       0,5, 0,2, 4,  0,1, 0,32'hFFFFFFFF, 0,1};
    tbl[3] = '{1,0,0,0, 3,3,0,0,       7,0, 0,0, 9,  1,0, 0,0,            1,0};
    tbl[4] = '{1,1,1,0, 50,5,11,13,    8,9, 1,0, 11, 1,1, 10,0,           0,1};

    repeat (2) @(negedge clock);
    #1;
    chk("reset stall", W'(stall), W'(0));
    chk("reset ctrl", W'({ctrl_MULT, ctrl_DIV}), W'(0));
    chk("reset wb_valid", W'({wb_valid_a, wb_valid_b}), W'(0));
    chk("reset operandA", data_operandA, '0);
    @(negedge clock);
    reset = 1;
    tick();

    for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv = '{default: 0};
      rv.ra = 1'($urandom_range(0, 1));
      rv.rb = rv.ra ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.da = 1'($urandom_range(0, 1));
      rv.db = 1'($urandom_range(0, 1));
      rv.a0 = $urandom_range(0, 5000);
      rv.b0 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 300);
      rv.a1 = $urandom;
      rv.b1 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 300);
      rv.rda = RW'($urandom);
      rv.rdb = RW'($urandom);
      rv.la = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 5);
      rv.lb = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 5);
      run_txn(model(rv), $sformatf("rnd%0d", i));
    end

    // flush two cycles after the start pulse, younger op waiting in DX
    pulse_div_q = {}; lat_q = {5, 2};
    req_a = 1; isdiv_a = 0; opA_a = 3; opB_a = 4; rd_a = 6; req_b = 0;
    tick(); tick(); tick();
    flush = 1; opA_a = 2; opB_a = 3; rd_a = 4;
    tick();
    chk("flush stall", W'(s_stall), W'(1));
    flush = 0;
    bad_cyc = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (!s_stall || s_wva || s_wvb) bad_cyc++;
    end
    chk("drain stall_no_wb", W'(bad_cyc), W'(0));
    pulse_div_q = {}; pulse_opa_q = {};
    tick();
    chk("post_drain accept stall", W'(s_stall), W'(1));
    chk("post_drain no early pulse", W'(pulse_div_q.size()), W'(0));
    tick();
    chk("post_drain fresh pulse", W'(s_mul), W'(1));
    chk("post_drain pulse opA", (pulse_opa_q.size() > 0) ? pulse_opa_q[0] : '1, W'(2));
    bad_cyc = 0;
    for (int c = 0; c < 20 && !(s_wva || s_wvb); c++) tick();
    req_a = 0;
    chk("post_drain wb_valid_a", W'(s_wva), W'(1));
    chk("post_drain wb_data_a", s_da, W'(6));
    chk("post_drain wb_rd_a", W'(s_rda), W'(4));
    $display("txn flush: drained, new op wb data=%0h rd=%0d", s_da, s_rda);

    // reset while slot B is running
    lat_q = {2, 4};
    req_a = 1; req_b = 1; isdiv_a = 0; isdiv_b = 0;
    opA_a = 5; opB_a = 5; opA_b = 3; opB_b = 3; rd_a = 1; rd_b = 2;
    for (int c = 0; c < 6; c++) tick();
    chk("pre_reset stall", W'(s_stall), W'(1));
    req_a = 0; req_b = 0;
    #2 reset = 0;
    #1;
    chk("async_reset stall", W'(stall), W'(0));
    chk("async_reset ctrl", W'({ctrl_MULT, ctrl_DIV}), W'(0));
    chk("async_reset operands", data_operandA | data_operandB, '0);
    chk("async_reset wb", W'({wb_valid_a, wb_valid_b, wb_exc_a, wb_exc_b}), W'(0));
    chk("async_reset wb_data", wb_data_a | wb_data_b, '0);
    chk("async_reset wb_rd", W'({wb_rd_a, wb_rd_b}), W'(0));
    @(negedge clock);
    reset = 1;
    bad_cyc = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_wva || s_wvb || s_stall) bad_cyc++;
    end
    chk("late_rdy ignored", W'(bad_cyc), W'(0));
    $display("txn reset: mid RUN_B reset, late RDY ignored");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
